// File: rtl/hybrid_mul_arbiter.sv
// hybrid_mul_arbiter: NREQ requesters share one 16x16 signed radix-4 Booth
// multiplier through a two-stage pipeline (A: operands, B: product) with a
// valid/ready response channel tagged by requester id.
// Optional feature macro: MUL_ARB_RR_EN selects round-robin arbitration;
// when it is undefined, the lowest valid index wins.

// Combinational 16x16 signed radix-4 Booth multiplier.
module hybrid_multiplier (
  input  logic [15:0] x,
  input  logic [15:0] y,
  output logic [31:0] p
);
  logic [16:0] y_ext;
  logic [31:0] xs;
  logic [31:0] pp [8];

  assign y_ext = {y, 1'b0};
  assign xs    = {{16{x[15]}}, x};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pp
      logic [2:0]  trip;
      logic [31:0] mag;
      assign trip = y_ext[2*gi+2 : 2*gi];
      // Recode one overlapping bit triplet into a Booth digit times x.
      always_comb begin
        case (trip)
          3'b001, 3'b010: mag = xs;
          3'b011:         mag = xs << 1;
          3'b100:         mag = -(xs << 1);
          3'b101, 3'b110: mag = -xs;
          default:        mag = '0;
        endcase
      end
      assign pp[gi] = mag << (2*gi);
    end
  endgenerate

  // Sum the weighted partial products modulo 2^32.
  always_comb begin
    p = '0;
    for (int i = 0; i < 8; i++) p = p + pp[i];
  end
endmodule

module hybrid_mul_arbiter #(
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [16*NREQ-1:0] req_x,
  input  logic [16*NREQ-1:0] req_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_id,
  output logic [31:0]       rsp_p,
  output logic              busy
);
  typedef enum logic [1:0] {EMPTY, A_ONLY, B_ONLY, FULL} state_t;

  state_t      state_reg, state_next;
  logic        a_full, b_full, b_drain, a_adv, a_accept, grant_any;
  logic [2:0]  win_id;
  logic [15:0] sel_x, sel_y;
  logic [15:0] a_x_reg, a_y_reg;
  logic [2:0]  a_id_reg, b_id_reg;
  logic [31:0] b_p_reg, mul_p;

  assign a_full    = (state_reg == A_ONLY) || (state_reg == FULL);
  assign b_full    = (state_reg == B_ONLY) || (state_reg == FULL);
  assign b_drain   = b_full && rsp_ready;
  assign a_adv     = a_full && (!b_full || b_drain);
  assign a_accept  = !a_full || a_adv;
  assign grant_any = a_accept && !rst && (|req_valid);

`ifdef MUL_ARB_RR_EN
  logic [2:0] ptr_reg;
  logic       found;

  // Round-robin search starting one past the last granted index.
  always_comb begin
    win_id = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (i == (int'(ptr_reg) + k) % NREQ)) begin
          win_id = 3'(i);
          found  = 1'b1;
        end
      end
    end
  end

  // Pointer remembers the last grant; reset makes requester 0 win first.
  always_ff @(posedge clk) begin
    if (rst)            ptr_reg <= 3'(NREQ - 1);
    else if (grant_any) ptr_reg <= win_id;
  end
`else
  // Fixed priority: the lowest valid index wins.
  always_comb begin
    win_id = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) win_id = 3'(k);
    end
  end
`endif

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = grant_any && (win_id == 3'(gi));
    end
  endgenerate

  // Route the winner's operands toward stage A.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == 3'(i)) begin
        sel_x = req_x[i*16 +: 16];
        sel_y = req_y[i*16 +: 16];
      end
    end
  end

  // Stage A captures operands and id on every grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_x_reg  <= '0;
      a_y_reg  <= '0;
      a_id_reg <= '0;
    end else if (grant_any) begin
      a_x_reg  <= sel_x;
      a_y_reg  <= sel_y;
      a_id_reg <= win_id;
    end
  end

  hybrid_multiplier u_mul (
    .x (a_x_reg),
    .y (a_y_reg),
    .p (mul_p)
  );

  // Stage B captures the product when A advances; holds under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_p_reg  <= '0;
      b_id_reg <= '0;
    end else if (a_adv) begin
      b_p_reg  <= mul_p;
      b_id_reg <= a_id_reg;
    end
  end

  // Occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= EMPTY;
    else     state_reg <= state_next;
  end

  // Occupancy next-state from grant, advance and drain events.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:  if (grant_any) state_next = A_ONLY;
      A_ONLY: state_next = grant_any ? FULL : B_ONLY;
      B_ONLY: begin
        if (b_drain) state_next = grant_any ? A_ONLY : EMPTY;
        else         state_next = grant_any ? FULL : B_ONLY;
      end
      FULL:   if (b_drain) state_next = grant_any ? FULL : B_ONLY;
      default: state_next = EMPTY;
    endcase
  end

  assign rsp_valid = b_full;
  assign rsp_id    = b_id_reg;
  assign rsp_p     = b_p_reg;
  assign busy      = (state_reg != EMPTY);
endmodule

// File: tb/tb_hybrid_mul_arbiter.sv
// Directed, table-driven bench for hybrid_mul_arbiter (NREQ=4).
module tb_hybrid_mul_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [63:0] req_x, req_y;
  logic        rsp_valid, rsp_ready, busy;
  logic [2:0]  rsp_id;
  logic [31:0] rsp_p;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    int          id;
    logic [31:0] p;
  } vec_t;

  vec_t vecs [10];

  hybrid_mul_arbiter #(.NREQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_slot(input int id, input logic [15:0] x, input logic [15:0] y);
    req_x[id*16 +: 16] = x;
    req_y[id*16 +: 16] = y;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0]  exp_r;
    logic [3:0]  pend;
    int          gr [10];
    logic [31:0] sp [16];
    int          xi, yi;

    vecs[0] = '{16'h0003, 16'hFFFB, 2, 32'hFFFFFFF1};
    vecs[1] = '{16'h8000, 16'h8000, 0, 32'h40000000};
    vecs[2] = '{16'h7FFF, 16'h8000, 1, 32'hC0008000};
    vecs[3] = '{16'h0000, 16'h1234, 3, 32'h00000000};
    vecs[4] = '{16'h7FFF, 16'h7FFF, 1, 32'h3FFF0001};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 0, 32'h00000001};
    vecs[6] = '{16'h1234, 16'h0010, 3, 32'h00012340};
    vecs[7] = '{16'hFFFF, 16'h8000, 2, 32'h00008000};
    vecs[8] = '{16'h0064, 16'hFF38, 0, 32'hFFFFB1E0};
    vecs[9] = '{16'h00FF, 16'h0101, 1, 32'h0000FFFF};

    // Reset state, with every requester asking.
    rst = 1'b1; req_valid = 4'hF; req_x = '0; req_y = '0; rsp_ready = 1'b0;
    step();
    step();
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_p", rsp_p, 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    step();
    rst = 1'b0; req_valid = '0; rsp_ready = 1'b1;

    // Single requests from the vector table: grant, 2-cycle latency, product.
    for (int v = 0; v < 10; v++) begin
      step();
      req_valid = 4'(1 << vecs[v].id);
      set_slot(vecs[v].id, vecs[v].x, vecs[v].y);
      #1;
      chk("vec_grant", 32'(req_ready), 32'(1 << vecs[v].id));
      step();
      req_valid = '0;
      #1;
      chk("vec_no_early_rsp", 32'(rsp_valid), 32'h0);
      chk("vec_busy", 32'(busy), 32'h1);
      step();
      #1;
      chk("vec_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("vec_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
      chk("vec_rsp_p", rsp_p, vecs[v].p);
      $display("vec %0d: id=%0d x=%h y=%h p=%h", v, rsp_id, vecs[v].x, vecs[v].y, rsp_p);
    end

    // Contention: all four valid every cycle.
    do_reset();
    for (int i = 0; i < 4; i++) set_slot(i, 16'(i + 1), 16'(10 * (i + 1)));
    for (int k = 0; k < 10; k++) begin
      step();
      req_valid = 4'hF;
      #1;
`ifdef MUL_ARB_RR_EN
      gr[k] = k % 4;
`else
      gr[k] = 0;
`endif
      chk("cont_grant", 32'(req_ready), 32'(1 << gr[k]));
      if (k >= 2) begin
        chk("cont_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("cont_rsp_id", 32'(rsp_id), 32'(gr[k-2]));
        chk("cont_rsp_p", rsp_p, 32'((gr[k-2] + 1) * (gr[k-2] + 1) * 10));
        $display("cont cycle %0d: grant=%b rsp id=%0d p=%h", k, req_ready, rsp_id, rsp_p);
      end
    end
    step();
    req_valid = '0;
    step();
    step();
    step();

    // Backpressure: three pending, consumer stalls five cycles.
    do_reset();
    set_slot(0, 16'h0007, 16'hFFFD);
    set_slot(1, 16'hFF9C, 16'h0032);
    set_slot(2, 16'h4000, 16'h0004);
    pend = 4'b0111;
    for (int k = 0; k < 11; k++) begin
      step();
      req_valid = pend;
      rsp_ready = (k >= 7);
      #1;
      case (k)
        0: exp_r = 4'b0001;
        1: exp_r = 4'b0010;
        7: exp_r = 4'b0100;
        default: exp_r = 4'b0000;
      endcase
      chk("bp_grant", 32'(req_ready), 32'(exp_r));
      pend = pend & ~exp_r;
      if (k >= 2 && k <= 7) begin
        chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
        chk("bp_hold_id", 32'(rsp_id), 32'h0);
        chk("bp_hold_p", rsp_p, 32'hFFFFFFEB);
      end
      if (k >= 2 && k <= 6) chk("bp_busy", 32'(busy), 32'h1);
      if (k == 8) begin
        chk("bp_rsp1_valid", 32'(rsp_valid), 32'h1);
        chk("bp_rsp1_id", 32'(rsp_id), 32'h1);
        chk("bp_rsp1_p", rsp_p, 32'hFFFFEC78);
      end
      if (k == 9) begin
        chk("bp_rsp2_valid", 32'(rsp_valid), 32'h1);
        chk("bp_rsp2_id", 32'(rsp_id), 32'h2);
        chk("bp_rsp2_p", rsp_p, 32'h00010000);
      end
      if (k == 10) begin
        chk("bp_drained", 32'(rsp_valid), 32'h0);
        chk("bp_idle", 32'(busy), 32'h0);
      end
      $display("bp cycle %0d: ready=%b rsp_valid=%0d id=%0d p=%h", k, req_ready, rsp_valid, rsp_id, rsp_p);
    end

    // Streaming: 16 back-to-back requests from requester 1.
    rsp_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step();
      if (k < 16) begin
        xi = 3 * k + 1;
        yi = k - 5;
        sp[k] = 32'(xi * yi);
        req_valid = 4'b0010;
        set_slot(1, 16'(xi), 16'(yi));
      end else begin
        req_valid = '0;
      end
      #1;
      if (k < 16) chk("stream_grant", 32'(req_ready), 32'h2);
      if (k >= 2) begin
        chk("stream_valid", 32'(rsp_valid), 32'h1);
        chk("stream_id", 32'(rsp_id), 32'h1);
        chk("stream_p", rsp_p, sp[k-2]);
        $display("stream %0d: id=%0d p=%h", k - 2, rsp_id, rsp_p);
      end
    end
    step();
    #1;
    chk("stream_done", 32'(rsp_valid), 32'h0);

    // Reset with two operations in flight.
    step();
    req_valid = 4'b1000;
    set_slot(3, 16'h0005, 16'h0006);
    #1;
    chk("midrst_grant3", 32'(req_ready), 32'h8);
    step();
    req_valid = 4'b0100;
    set_slot(2, 16'h0002, 16'h0002);
    #1;
    chk("midrst_grant2", 32'(req_ready), 32'h4);
    step();
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("midrst_ready_in_rst", 32'(req_ready), 32'h0);
    step();
    rst = 1'b0;
    req_valid = '0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      #1;
      chk("midrst_no_stale", 32'(rsp_valid), 32'h0);
    end
    step();
    req_valid = 4'hF;
    #1;
    chk("midrst_first_grant", 32'(req_ready), 32'h1);
    $display("post-reset grant=%b", req_ready);
    step();
    req_valid = '0;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
